// File: rtl/dcache_tag_ctrl_pkg.sv
// rtl/dcache_tag_ctrl_pkg.sv - shared geometry, tag layout and state encoding for the dcache tag controller
package dcache_tag_ctrl_pkg;

  localparam int NL        = 256;
  localparam int LSS       = 8;
  localparam int LSH       = LSS + 4;
  localparam int PSL       = LSH + 1;
  localparam int PW        = 32 - PSL;
  localparam int TS        = 2 + PW;
  localparam int D_BIT     = TS - 1;
  localparam int V_BIT     = TS - 2;
  localparam int BURST_LEN = 8;
  localparam int WCW       = $clog2(BURST_LEN);

  typedef enum logic [3:0] {
    INIT, IDLE, LOOKUP, WB, FILL, UPDATE, FL_RD, FL_CHK, FL_WB
  } state_e;

  function automatic logic [LSS-1:0] line_of(input logic [31:0] addr);
    return addr[LSH:5];
  endfunction

  function automatic logic [PW-1:0] page_of(input logic [31:0] addr);
    return addr[31:PSL];
  endfunction

endpackage

// File: rtl/dcache_burst_cnt.sv
// rtl/dcache_burst_cnt.sv - burst word counter and mem_req hold shared by writeback, linefill and flush bursts
module dcache_burst_cnt
  import dcache_tag_ctrl_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic           mem_ack_i,
  output logic           mem_req_o,
  output logic [WCW-1:0] word_cnt_o,
  output logic           last_o
);

  logic           mem_req_q;
  logic [WCW-1:0] cnt_q;

  assign mem_req_o  = mem_req_q;
  assign word_cnt_o = cnt_q;
  assign last_o     = mem_req_q && mem_ack_i && (cnt_q == WCW'(BURST_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start_i) begin
      mem_req_q <= 1'b1;
      cnt_q     <= '0;
    end else if (mem_req_q && mem_ack_i) begin
      cnt_q <= cnt_q + WCW'(1);
      if (last_o) mem_req_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - dtag sequencing: hit/miss, writeback, linefill, flush sweep and reset invalidate
module dcache_tag_ctrl
  import dcache_tag_ctrl_pkg::*;
(
  input  logic           nGCLK,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           cpu_wr,
  input  logic [31:0]    cpu_addr,
  output logic           cpu_ready,
  input  logic           flush_req,
  output logic           flush_busy,
  output logic [LSS-1:0] tag_read_sel,
  input  logic [TS-1:0]  tag_read_port,
  output logic [LSS-1:0] tag_write_sel,
  output logic [TS-1:0]  tag_write_port,
  output logic           tag_wr_ena,
  output logic           mem_req,
  output logic           mem_wr,
  output logic [31:0]    mem_addr,
  input  logic           mem_ack,
  output logic [2:0]     word_cnt,
  output logic           fill_we
);

  state_e         state_q;
  logic [LSS-1:0] index_q;
  logic           cpu_ready_q;
  logic           flush_busy_q;
  logic           mem_wr_q;
  logic [31:0]    mem_addr_q;
  logic           tag_we_q;
  logic [LSS-1:0] tag_wsel_q;
  logic [TS-1:0]  tag_wdata_q;
  logic           start_q;
  logic           burst_last;

  logic [PW-1:0]  rd_page;
  logic           rd_v;
  logic           rd_d;
  logic           hit;
  logic           idx_last;
  logic           unused_addr_bits;

  assign rd_page          = tag_read_port[PW-1:0];
  assign rd_v             = tag_read_port[V_BIT];
  assign rd_d             = tag_read_port[D_BIT];
  assign hit              = rd_v && (rd_page == page_of(cpu_addr));
  assign idx_last         = (index_q == LSS'(NL - 1));
  assign unused_addr_bits = ^cpu_addr[4:0];

  dcache_burst_cnt u_burst (
    .clk_i      (nGCLK),
    .reset_i    (reset),
    .start_i    (start_q),
    .mem_ack_i  (mem_ack),
    .mem_req_o  (mem_req),
    .word_cnt_o (word_cnt),
    .last_o     (burst_last)
  );

  // Read select is combinational so the tag arrives in LOOKUP one cycle after the request.
  always_comb begin
    tag_read_sel = '0;
    case (state_q)
      IDLE, LOOKUP, UPDATE: tag_read_sel = line_of(cpu_addr);
      FL_RD:                tag_read_sel = index_q;
      default:              tag_read_sel = '0;
    endcase
  end

  assign cpu_ready      = cpu_ready_q;
  assign flush_busy     = flush_busy_q;
  assign tag_write_sel  = tag_wsel_q;
  assign tag_write_port = tag_wdata_q;
  assign tag_wr_ena     = tag_we_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign fill_we        = (state_q == FILL) && mem_ack;

  always_ff @(posedge nGCLK) begin
    if (reset) begin
      state_q      <= INIT;
      index_q      <= '0;
      cpu_ready_q  <= 1'b0;
      flush_busy_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      tag_we_q     <= 1'b0;
      tag_wsel_q   <= '0;
      tag_wdata_q  <= '0;
      start_q      <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      tag_we_q    <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        INIT: begin
          tag_we_q    <= 1'b1;
          tag_wsel_q  <= index_q;
          tag_wdata_q <= '0;
          index_q     <= index_q + LSS'(1);
          if (idx_last) state_q <= IDLE;
        end
        IDLE: begin
          if (flush_req) begin
            flush_busy_q <= 1'b1;
            index_q      <= '0;
            state_q      <= FL_RD;
          end else if (cpu_req && !cpu_ready_q) begin
            // cpu_req is still high during the ready pulse; that cycle is the handshake, not a new access
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (cpu_wr && !rd_d) begin
              tag_we_q    <= 1'b1;
              tag_wsel_q  <= line_of(cpu_addr);
              tag_wdata_q <= {1'b1, 1'b1, rd_page};
            end
          end else if (rd_v && rd_d) begin
            state_q    <= WB;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {rd_page, line_of(cpu_addr), 5'b0};
            start_q    <= 1'b1;
          end else begin
            state_q    <= FILL;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {cpu_addr[31:5], 5'b0};
            start_q    <= 1'b1;
          end
        end
        WB: begin
          if (burst_last) begin
            state_q    <= FILL;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {cpu_addr[31:5], 5'b0};
            start_q    <= 1'b1;
          end
        end
        FILL: begin
          if (burst_last) begin
            state_q     <= UPDATE;
            tag_we_q    <= 1'b1;
            tag_wsel_q  <= line_of(cpu_addr);
            tag_wdata_q <= {cpu_wr, 1'b1, page_of(cpu_addr)};
          end
        end
        UPDATE: state_q <= LOOKUP;
        FL_RD:  state_q <= FL_CHK;
        FL_CHK: begin
          tag_we_q    <= 1'b1;
          tag_wsel_q  <= index_q;
          tag_wdata_q <= '0;
          if (rd_v && rd_d) begin
            state_q    <= FL_WB;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {rd_page, index_q, 5'b0};
            start_q    <= 1'b1;
          end else if (idx_last) begin
            flush_busy_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            index_q <= index_q + LSS'(1);
            state_q <= FL_RD;
          end
        end
        FL_WB: begin
          if (burst_last) begin
            if (idx_last) begin
              flush_busy_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              index_q <= index_q + LSS'(1);
              state_q <= FL_RD;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb/tb_dcache_tag_ctrl.sv - directed self-checking bench for dcache_tag_ctrl with tag RAM and memory models
module tb_dcache_tag_ctrl;
  import dcache_tag_ctrl_pkg::*;

  localparam int LIM = 200;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cpu_req = 1'b0;
  logic           cpu_wr = 1'b0;
  logic [31:0]    cpu_addr = '0;
  logic           cpu_ready;
  logic           flush_req = 1'b0;
  logic           flush_busy;
  logic [LSS-1:0] tag_read_sel;
  logic [TS-1:0]  tag_read_port = '0;
  logic [LSS-1:0] tag_write_sel;
  logic [TS-1:0]  tag_write_port;
  logic           tag_wr_ena;
  logic           mem_req;
  logic           mem_wr;
  logic [31:0]    mem_addr;
  logic           mem_ack = 1'b0;
  logic [2:0]     word_cnt;
  logic           fill_we;

  dcache_tag_ctrl dut (
    .nGCLK(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .flush_req(flush_req), .flush_busy(flush_busy),
    .tag_read_sel(tag_read_sel), .tag_read_port(tag_read_port), .tag_write_sel(tag_write_sel),
    .tag_write_port(tag_write_port), .tag_wr_ena(tag_wr_ena), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .word_cnt(word_cnt), .fill_we(fill_we)
  );

  always #5 clk = ~clk;

  // dtag model: registered read, same-line write forwarded to the read port
  logic [TS-1:0] tag_mem [NL];
  always @(posedge clk) begin
    if (tag_wr_ena) tag_mem[tag_write_sel] <= tag_write_port;
    tag_read_port <= (tag_wr_ena && tag_write_sel == tag_read_sel) ? tag_write_port : tag_mem[tag_read_sel];
  end

  int checks = 0;
  int errors = 0;
  int ack_idx = 0, wc_err = 0, fwe_err = 0, ready_cnt = 0, wr_cnt = 0, wr_err = 0;
  bit init_mon = 1'b0;
  logic [31:0] b_addr[$];
  logic        b_wr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory model acks every cycle of a burst; log bursts, word indices and tag writes
  always begin
    @(negedge clk);
    mem_ack = mem_req;
    #1;
    if (cpu_ready) ready_cnt++;
    if (init_mon && tag_wr_ena) begin
      if (tag_write_sel != wr_cnt[LSS-1:0] || tag_write_port != '0) wr_err++;
      wr_cnt++;
    end
    if (mem_ack) begin
      if (word_cnt != ack_idx[2:0]) wc_err++;
      if (fill_we != !mem_wr) fwe_err++;
      if (ack_idx == 0) begin
        b_addr.push_back(mem_addr);
        b_wr.push_back(mem_wr);
      end
      ack_idx = (ack_idx + 1) % 8;
    end
  end

  task automatic access(input logic wr, input logic [31:0] addr, output int lat);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; lat = 0;
    while (!cpu_ready && lat < LIM) begin
      @(posedge clk); #1;
      lat++;
    end
    cpu_req = 1'b0;
  endtask

  task automatic clear_log();
    b_addr.delete();
    b_wr.delete();
  endtask

  function automatic int nonzero_tags();
    int n = 0;
    for (int i = 0; i < NL; i++) if (tag_mem[i] != '0) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int rc;
    for (int i = 0; i < NL; i++) tag_mem[i] = '1;
    init_mon = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cpu_ready, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_mreq", mem_req, 0);
    check("rst_mwr", mem_wr, 0);
    check("rst_twe", tag_wr_ena, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_sels", {tag_read_sel, tag_write_sel}, 0);

    reset = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_2040;
    repeat (NL) @(posedge clk);
    #1; cpu_req = 1'b0;
    @(negedge clk); #2;
    check("init_writes", wr_cnt, NL);
    check("init_seq", wr_err, 0);
    check("init_noready", ready_cnt, 0);
    init_mon = 1'b0;
    @(posedge clk); #1;
    check("init_tags_zero", nonzero_tags(), 0);

    clear_log();
    access(1'b0, 32'h0000_2040, lat);
    check("miss_ready", lat < LIM, 1);
    check("miss_bursts", b_addr.size(), 1);
    check("miss_addr", b_addr.size() > 0 ? b_addr[0] : 32'hdead_beef, 32'h0000_2040);
    check("miss_wr", b_wr.size() > 0 ? b_wr[0] : 1'b1, 0);
    check("miss_tag", tag_mem[2], 32'h0008_0001);

    clear_log();
    access(1'b1, 32'h0000_2044, lat);
    check("st_hit_lat", lat, 2);
    repeat (2) @(posedge clk);
    #1;
    check("st_dirty_tag", tag_mem[2], 32'h0018_0001);
    access(1'b0, 32'h0000_2048, lat);
    check("ld_hit_lat", lat, 2);
    check("hit_no_burst", b_addr.size(), 0);

    clear_log();
    access(1'b0, 32'h0004_2040, lat);
    check("wb_ready", lat < LIM, 1);
    check("wb_bursts", b_addr.size(), 2);
    check("wb_addr", b_addr.size() > 0 ? b_addr[0] : 32'hdead_beef, 32'h0000_2040);
    check("wb_wr", b_wr.size() > 0 ? b_wr[0] : 1'b0, 1);
    check("refill_addr", b_addr.size() > 1 ? b_addr[1] : 32'hdead_beef, 32'h0004_2040);
    check("refill_wr", b_wr.size() > 1 ? b_wr[1] : 1'b1, 0);
    check("wb_tag", tag_mem[2], 32'h0008_0021);

    access(1'b1, 32'h0000_00e0, lat);
    access(1'b1, 32'h0004_2044, lat);
    repeat (2) @(posedge clk);
    #1;
    check("st_miss_tag7", tag_mem[7], 32'h0018_0000);
    check("st_hit_tag2", tag_mem[2], 32'h0018_0021);

    clear_log();
    flush_req = 1'b1;
    n = 0;
    while (!flush_busy && n < 10) begin @(posedge clk); #1; n++; end
    check("flush_start", flush_busy, 1);
    flush_req = 1'b0;
    n = 0;
    while (flush_busy && n < 3000) begin @(posedge clk); #1; n++; end
    check("flush_done", flush_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("flush_bursts", b_addr.size(), 2);
    check("flush_wb0", b_addr.size() > 0 ? b_addr[0] : 32'hdead_beef, 32'h0004_2040);
    check("flush_wb1", b_addr.size() > 1 ? b_addr[1] : 32'hdead_beef, 32'h0000_00e0);
    check("flush_wr", (b_wr.size() > 1) ? {b_wr[0], b_wr[1]} : 2'b00, 2'b11);
    check("flush_tags_zero", nonzero_tags(), 0);
    check("burst_wcnt", wc_err, 0);
    check("fill_we", fwe_err, 0);

    ack_idx = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_4000;
    n = 0;
    while (ack_idx != 3 && n < 100) begin @(negedge clk); #2; n++; end
    check("abort_at_ack3", ack_idx, 3);
    rc = ready_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mreq", mem_req, 0);
    check("abort_ready", cpu_ready, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; ack_idx = 0; wr_cnt = 0; wr_err = 0; init_mon = 1'b1;
    repeat (NL) @(posedge clk);
    @(negedge clk); #2;
    check("reinit_writes", wr_cnt, NL);
    check("reinit_seq", wr_err, 0);
    check("abort_noready", ready_cnt - rc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
